// File: rtl/vend_ctrl_fsm.sv
// Vending machine sequencer: conditions raw switches, buttons and coin sensors,
// then produces the 4-bit state code and gated one-cycle pulses for the datapath.
`timescale 1ns/1ps
module vend_ctrl_fsm #(
    parameter logic [15:0] DB_CYC      = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1500000000,
    parameter logic [31:0] SHOW_CYC    = 32'd100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_sw,
    input  logic       admin_sw,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    input  logic       btn_plus,
    input  logic       btn_minus,
    input  logic       coin1,
    input  logic       coin2,
    input  logic       coin5,
    input  logic       coin10,
    input  logic [6:0] sum,
    input  logic [6:0] total,
    input  logic       sold_out,
    output logic [3:0] state,
    output logic       switch_plus,
    output logic       switch_minus,
    output logic       coin1_p,
    output logic       coin2_p,
    output logic       coin5_p,
    output logic       coin10_p,
    output logic       coin_reject,
    output logic       timeout_flag
);

    typedef enum logic [3:0] {
        OFF       = 4'b0000,
        BROWSE    = 4'b0001,
        QTY       = 4'b0011,
        PAY       = 4'b0010,
        SUCCESS   = 4'b0110,
        REFUND    = 4'b0100,
        ADMIN     = 4'b1101,
        RESTOCK   = 4'b1111,
        RSTK_DONE = 4'b1011,
        CLEAR     = 4'b1110
    } state_t;

    localparam int I_CONFIRM = 0;
    localparam int I_CANCEL  = 1;
    localparam int I_PLUS    = 2;
    localparam int I_MINUS   = 3;

    logic [1:0]  sw_s1, sw_s2;
    logic        power_on, admin_on;
    logic [7:0]  raw, in_s1, in_s2, db, db_q, pulse;
    logic [15:0] db_cnt [8];
    logic [3:0]  coin_pay;
    logic        confirm, cancel, pm_ok;
    logic [31:0] timer;
    state_t      st;

    assign raw      = {coin10, coin5, coin2, coin1, btn_minus, btn_plus, btn_cancel, btn_confirm};
    assign power_on = sw_s2[0];
    assign admin_on = sw_s2[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            in_s1 <= '0;
            in_s2 <= '0;
            db    <= '0;
            db_q  <= '0;
            // NOTE: db_cnt is a tiny per-input flop array, not a RAM, so it is reset with the rest.
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            sw_s1 <= {admin_sw, power_sw};
            sw_s2 <= sw_s1;
            in_s1 <= raw;
            in_s2 <= in_s1;
            db_q  <= db;
            for (int i = 0; i < 8; i++) begin
                if (in_s2[i] != db[i]) begin
                    if (db_cnt[i] == DB_CYC - 16'd1) begin
                        db[i]     <= in_s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Rising edge of the debounced level; both terms are flops, so the pulse is glitch-free.
    assign pulse   = db & ~db_q;
    assign confirm = pulse[I_CONFIRM];
    assign cancel  = pulse[I_CANCEL];

    assign pm_ok        = (st == BROWSE) || (st == QTY) || (st == ADMIN) || (st == RESTOCK);
    assign switch_plus  = pm_ok & pulse[I_PLUS] & ~pulse[I_MINUS];
    assign switch_minus = pm_ok & pulse[I_MINUS] & ~pulse[I_PLUS];

    assign coin_pay    = (st == PAY) ? pulse[7:4] : 4'b0000;
    assign coin1_p     = coin_pay[0];
    assign coin2_p     = coin_pay[1];
    assign coin5_p     = coin_pay[2];
    assign coin10_p    = coin_pay[3];
    assign coin_reject = (st != PAY) & (|pulse[7:4]);

    assign state = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= OFF;
            timer        <= '0;
            timeout_flag <= 1'b0;
        end else if (!power_on) begin
            st    <= OFF;
            timer <= '0;
        end else begin
            // Only PAY, SUCCESS and REFUND count; every other state parks the timer at zero.
            timer <= '0;
            case (st)
                OFF: st <= admin_on ? ADMIN : BROWSE;
                BROWSE: begin
                    if (admin_on) begin
                        st <= ADMIN;
                    end else if (confirm && !sold_out) begin
                        st           <= QTY;
                        timeout_flag <= 1'b0;
                    end
                end
                QTY: begin
                    if (cancel)       st <= BROWSE;
                    else if (confirm) st <= PAY;
                end
                PAY: begin
                    if (sum >= total) begin
                        st <= SUCCESS;
                    end else if (cancel) begin
                        st <= REFUND;
                    end else if (timer == TIMEOUT_CYC - 32'd1) begin
                        st           <= REFUND;
                        timeout_flag <= 1'b1;
                    end else if (|coin_pay) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                SUCCESS, REFUND: begin
                    if (timer == SHOW_CYC - 32'd1) st <= BROWSE;
                    else                           timer <= timer + 32'd1;
                end
                ADMIN: begin
                    if (!admin_on)    st <= BROWSE;
                    else if (confirm) st <= RESTOCK;
                    else if (cancel)  st <= CLEAR;
                end
                RESTOCK: begin
                    if (cancel)       st <= ADMIN;
                    else if (confirm) st <= RSTK_DONE;
                end
                RSTK_DONE, CLEAR: st <= ADMIN;
                default: st <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_fsm.sv
// Directed bench for vend_ctrl_fsm: a vector table of button/coin presses plus
// hand-timed sequences for purchase, timeouts, priorities, reset and admin flow.
`timescale 1ns/1ps
module tb_vend_ctrl_fsm;

    localparam logic [3:0] S_OFF       = 4'b0000;
    localparam logic [3:0] S_BROWSE    = 4'b0001;
    localparam logic [3:0] S_QTY       = 4'b0011;
    localparam logic [3:0] S_PAY       = 4'b0010;
    localparam logic [3:0] S_SUCCESS   = 4'b0110;
    localparam logic [3:0] S_REFUND    = 4'b0100;
    localparam logic [3:0] S_ADMIN     = 4'b1101;
    localparam logic [3:0] S_RESTOCK   = 4'b1111;
    localparam logic [3:0] S_RSTK_DONE = 4'b1011;
    localparam logic [3:0] S_CLEAR     = 4'b1110;

    logic       clk = 1'b0;
    logic       rst_n, power_sw, admin_sw;
    logic       btn_confirm, btn_cancel, btn_plus, btn_minus;
    logic       coin1, coin2, coin5, coin10;
    logic [6:0] sum, total;
    logic       sold_out;
    logic [3:0] state;
    logic       switch_plus, switch_minus;
    logic       coin1_p, coin2_p, coin5_p, coin10_p, coin_reject, timeout_flag;

    int checks   = 0;
    int failures = 0;

    vend_ctrl_fsm #(
        .DB_CYC      (16'd4),
        .TIMEOUT_CYC (32'd20),
        .SHOW_CYC    (32'd8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .power_sw     (power_sw),
        .admin_sw     (admin_sw),
        .btn_confirm  (btn_confirm),
        .btn_cancel   (btn_cancel),
        .btn_plus     (btn_plus),
        .btn_minus    (btn_minus),
        .coin1        (coin1),
        .coin2        (coin2),
        .coin5        (coin5),
        .coin10       (coin10),
        .sum          (sum),
        .total        (total),
        .sold_out     (sold_out),
        .state        (state),
        .switch_plus  (switch_plus),
        .switch_minus (switch_minus),
        .coin1_p      (coin1_p),
        .coin2_p      (coin2_p),
        .coin5_p      (coin5_p),
        .coin10_p     (coin10_p),
        .coin_reject  (coin_reject),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    // Press mask bits: 0 confirm, 1 cancel, 2 plus, 3 minus, 4 coin1, 5 coin2, 6 coin5, 7 coin10.
    // Output vector bits: 6 plus, 5 minus, 4 coin10_p, 3 coin5_p, 2 coin2_p, 1 coin1_p, 0 reject.
    typedef struct {
        string      name;
        logic [7:0] mask;
        logic       adm;
        logic       sold;
        logic [6:0] sum;
        logic [6:0] total;
        logic [3:0] exp_state;
        logic [6:0] exp_outs;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string n, input logic [7:0] m, input logic a,
                                input logic s, input logic [6:0] su, input logic [6:0] to,
                                input logic [3:0] es, input logic [6:0] eo);
        vec_t v;
        v.name = n; v.mask = m; v.adm = a; v.sold = s;
        v.sum = su; v.total = to; v.exp_state = es; v.exp_outs = eo;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {switch_plus, switch_minus, coin10_p, coin5_p, coin2_p, coin1_p, coin_reject};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [7:0] m);
        {coin10, coin5, coin2, coin1, btn_minus, btn_plus, btn_cancel, btn_confirm} = m;
    endtask

    // Raise the raw inputs and return in the cycle the debounced pulse is visible.
    task automatic press(input logic [7:0] m);
        set_raw(m);
        repeat (6) step();
        set_raw(8'h00);
    endtask

    task automatic apply_vec(input vec_t v);
        admin_sw = v.adm;
        sold_out = v.sold;
        sum      = v.sum;
        total    = v.total;
        press(v.mask);
        check({v.name, "_outs"}, 32'(outs()), 32'(v.exp_outs));
        step();
        check({v.name, "_state"}, 32'(state), 32'(v.exp_state));
        repeat (6) step();
    endtask

    int plus_cnt, coin_cnt, rej_cnt;

    initial begin
        rst_n = 1'b0; power_sw = 1'b0; admin_sw = 1'b0; sold_out = 1'b0;
        sum = '0; total = '0;
        set_raw(8'h00);

        vq.push_back(mk("plus_browse",     8'h04, 0, 0, 0,  0, S_BROWSE,  7'b1000000));
        vq.push_back(mk("minus_browse",    8'h08, 0, 0, 0,  0, S_BROWSE,  7'b0100000));
        vq.push_back(mk("pm_clash",        8'h0C, 0, 0, 0,  0, S_BROWSE,  7'b0000000));
        vq.push_back(mk("coin10_browse",   8'h80, 0, 0, 0,  0, S_BROWSE,  7'b0000001));
        vq.push_back(mk("confirm_soldout", 8'h01, 0, 1, 0,  0, S_BROWSE,  7'b0000000));
        vq.push_back(mk("admin_on",        8'h00, 1, 0, 0,  0, S_ADMIN,   7'b0000000));
        vq.push_back(mk("plus_admin",      8'h04, 1, 0, 0,  0, S_ADMIN,   7'b1000000));
        vq.push_back(mk("confirm_admin",   8'h01, 1, 0, 0,  0, S_RESTOCK, 7'b0000000));
        vq.push_back(mk("minus_restock",   8'h08, 1, 0, 0,  0, S_RESTOCK, 7'b0100000));
        vq.push_back(mk("both_restock",    8'h03, 1, 0, 0,  0, S_ADMIN,   7'b0000000));
        vq.push_back(mk("coin1_admin",     8'h10, 1, 0, 0,  0, S_ADMIN,   7'b0000001));
        vq.push_back(mk("admin_off",       8'h00, 0, 0, 0,  0, S_BROWSE,  7'b0000000));
        vq.push_back(mk("confirm_browse",  8'h01, 0, 0, 0,  0, S_QTY,     7'b0000000));
        vq.push_back(mk("plus_qty",        8'h04, 0, 0, 0,  0, S_QTY,     7'b1000000));
        vq.push_back(mk("both_qty",        8'h03, 0, 0, 0,  0, S_BROWSE,  7'b0000000));
        vq.push_back(mk("confirm_browse2", 8'h01, 0, 0, 0,  0, S_QTY,     7'b0000000));
        vq.push_back(mk("confirm_qty",     8'h01, 0, 0, 7, 12, S_PAY,     7'b0000000));
        vq.push_back(mk("coin5_pay",       8'h40, 0, 0, 7, 12, S_PAY,     7'b0001000));

        // Reset and power-up
        repeat (3) step();
        check("rst_state", 32'(state), 32'(S_OFF));
        check("rst_outs", 32'(outs()), 32'h0);
        check("rst_flag", 32'(timeout_flag), 32'h0);
        rst_n = 1'b1; power_sw = 1'b1;
        repeat (2) step();
        check("off_before_sync", 32'(state), 32'(S_OFF));
        step();
        check("power_on_browse", 32'(state), 32'(S_BROWSE));

        // Plus pulse latency: first visible after the 6th edge, exactly once while held
        set_raw(8'h04);
        repeat (5) step();
        check("plus_early", 32'(switch_plus), 32'h0);
        step();
        check("plus_edge6", 32'(switch_plus), 32'h1);
        step();
        check("plus_once", 32'(switch_plus), 32'h0);
        set_raw(8'h00);
        repeat (7) step();

        foreach (vq[i]) apply_vec(vq[i]);

        // Purchase completes when sum reaches total, then SUCCESS dwells 8 cycles
        sum = 7'd12;
        step();
        check("purchase_success", 32'(state), 32'(S_SUCCESS));
        repeat (7) step();
        check("success_hold", 32'(state), 32'(S_SUCCESS));
        step();
        check("success_to_browse", 32'(state), 32'(S_BROWSE));

        // Plain timeout: REFUND 20 cycles after entering PAY
        sum = 7'd0; total = 7'd12;
        press(8'h01); step();
        check("to1_qty", 32'(state), 32'(S_QTY));
        repeat (6) step();
        press(8'h01); step();
        check("to1_pay", 32'(state), 32'(S_PAY));
        repeat (19) step();
        check("to1_pay_hold", 32'(state), 32'(S_PAY));
        step();
        check("to1_refund", 32'(state), 32'(S_REFUND));
        check("to1_flag", 32'(timeout_flag), 32'h1);
        repeat (8) step();
        check("to1_browse", 32'(state), 32'(S_BROWSE));
        check("to1_flag_kept", 32'(timeout_flag), 32'h1);

        // Timeout restarted by a coin at cycle 10; plus held in PAY never passes
        press(8'h01); step();
        check("to2_qty", 32'(state), 32'(S_QTY));
        check("flag_clear_qty", 32'(timeout_flag), 32'h0);
        repeat (6) step();
        press(8'h01); step();
        check("to2_pay", 32'(state), 32'(S_PAY));
        btn_plus = 1'b1;
        plus_cnt = 0; coin_cnt = 0; rej_cnt = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 5) coin1 = 1'b1;
            step();
            plus_cnt += int'(switch_plus);
            coin_cnt += int'(coin1_p);
            rej_cnt  += int'(coin_reject);
            if (cyc == 10) check("to2_coin_cyc10", 32'(coin1_p), 32'h1);
            if (cyc == 12) coin1 = 1'b0;
            if (cyc == 20) begin
                check("to2_restarted", 32'(state), 32'(S_PAY));
                btn_plus = 1'b0;
            end
        end
        check("to2_pay_hold", 32'(state), 32'(S_PAY));
        step();
        check("to2_refund", 32'(state), 32'(S_REFUND));
        check("to2_flag", 32'(timeout_flag), 32'h1);
        check("plus_gated_pay", 32'(plus_cnt), 32'h0);
        check("coin_one_pulse", 32'(coin_cnt), 32'h1);
        check("no_reject_pay", 32'(rej_cnt), 32'h0);
        repeat (8) step();
        check("to2_browse", 32'(state), 32'(S_BROWSE));

        // sum>=total beats cancel in the same cycle
        press(8'h01); step();
        repeat (6) step();
        press(8'h01); step();
        check("prio_pay", 32'(state), 32'(S_PAY));
        set_raw(8'h02);
        repeat (6) step();
        sum = 7'd12;
        set_raw(8'h00);
        step();
        check("prio_sum_over_cancel", 32'(state), 32'(S_SUCCESS));
        repeat (8) step();
        check("prio_browse", 32'(state), 32'(S_BROWSE));
        sum = 7'd0;

        // Synchronous reset while in PAY
        press(8'h01); step();
        repeat (6) step();
        press(8'h01); step();
        check("rst_pay_entry", 32'(state), 32'(S_PAY));
        rst_n = 1'b0;
        step();
        check("rst_pay_state", 32'(state), 32'(S_OFF));
        check("rst_pay_flag", 32'(timeout_flag), 32'h0);
        rst_n = 1'b1;
        repeat (3) step();
        check("recover_browse", 32'(state), 32'(S_BROWSE));

        // Admin flow, one-cycle RSTK_DONE/CLEAR, power-off priority
        admin_sw = 1'b1;
        repeat (3) step();
        check("adm_enter", 32'(state), 32'(S_ADMIN));
        press(8'h01); step();
        check("adm_restock", 32'(state), 32'(S_RESTOCK));
        repeat (6) step();
        press(8'h01); step();
        check("adm_rstk_done", 32'(state), 32'(S_RSTK_DONE));
        step();
        check("adm_after_done", 32'(state), 32'(S_ADMIN));
        press(8'h02); step();
        check("adm_clear", 32'(state), 32'(S_CLEAR));
        step();
        check("adm_after_clear", 32'(state), 32'(S_ADMIN));
        repeat (6) step();
        press(8'h01); step();
        check("adm_restock2", 32'(state), 32'(S_RESTOCK));
        power_sw = 1'b0;
        repeat (2) step();
        check("pwr_off_sync", 32'(state), 32'(S_RESTOCK));
        step();
        check("pwr_off", 32'(state), 32'(S_OFF));
        power_sw = 1'b1;
        repeat (3) step();
        check("pwr_on_admin", 32'(state), 32'(S_ADMIN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
